// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM port arbiter.
package inst_rom_arbiter_pkg;

  localparam int ADDR_BUS       = 32;
  localparam int INST_BUS       = 32;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

  // Who owns the response slot in the following cycle.
  typedef enum logic [1:0] {
    GRANT_IDLE = 2'b00,
    GRANT_IF   = 2'b01,
    GRANT_DM   = 2'b10
  } grant_state_e;

  // ROM words are 4-byte aligned; anything else is an error access.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_arbiter_if.sv
// Requester/ROM bundle for the arbiter. The master side holds both
// requesters and the ROM; the slave side is the arbiter itself.
interface inst_rom_arbiter_if
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int DATA_W = INST_BUS
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_inst;
  logic              if_err;

  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_data;
  logic              dm_err;

  logic              stall_req;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_addr, rom_inst,
    input  if_gnt, if_valid, if_inst, if_err,
    input  dm_gnt, dm_valid, dm_data, dm_err,
    input  stall_req, rom_en, rom_addr
  );

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_addr, rom_inst,
    output if_gnt, if_valid, if_inst, if_err,
    output dm_gnt, dm_valid, dm_data, dm_err,
    output stall_req, rom_en, rom_addr
  );

endinterface

// File: rtl/inst_rom_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles in which fetch asked and lost.
// max_reached_o tells the arbiter to hand the next contested cycle to fetch.
module rom_arb_starve_cnt
  import inst_rom_arbiter_pkg::*;
#(
  parameter int MAX   = STARVE_MAX_DEF,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_reached_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; increment stops at MAX (stays 0 when MAX is 0).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max_reached_o = (MAX != 0) && (cnt_q == MAX_C);

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares one combinational instruction-ROM port between IF fetch and MEM
// literal loads. One access per cycle, response registered one cycle later.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_BUS,
  parameter int DATA_W     = INST_BUS,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  inst_rom_arbiter_if.slave  bus
);

  logic              in_reset;
  logic              force_if;
  logic              if_gnt;
  logic              dm_gnt;
  logic              any_gnt;
  logic              rom_aligned;
  logic              if_take;
  logic              dm_take;
  logic              if_valid;
  logic              dm_valid;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] dm_data_q;
  logic              if_err_q;
  logic              dm_err_q;
  grant_state_e      state_q;
  grant_state_e      state_d;

  // Grants are combinational, so reset has to mask them directly.
  assign in_reset = (rst == RST_ENABLE);

  // Data side wins contention unless fetch has been starved long enough.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!in_reset) begin
      if (bus.if_req && (!bus.dm_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (bus.dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // ROM address follows the winner; parked at zero when nobody is granted.
  always_comb begin
    rom_addr = '0;
    if (if_gnt) begin
      rom_addr = bus.if_addr;
    end else if (dm_gnt) begin
      rom_addr = bus.dm_addr;
    end
  end

  assign any_gnt     = if_gnt | dm_gnt;
  assign rom_aligned = is_word_aligned(rom_addr[1:0]);
  // Misaligned accesses return a zero word instead of whatever the ROM shows.
  assign rom_word    = rom_aligned ? bus.rom_inst : DATA_W'(ZERO_WORD);
  // A flushed fetch still consumed the port but produces no response.
  assign if_take     = if_gnt & ~bus.if_flush;
  assign dm_take     = dm_gnt;

  rom_arb_starve_cnt #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_starve_cnt (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (bus.if_req & ~if_gnt),
    .clr_i         (if_gnt),
    .max_reached_o (force_if)
  );

  // Grant-state register: remembers which requester the next cycle answers.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= GRANT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next grant state from this cycle's winner (flushed fetch answers nobody).
  always_comb begin
    state_d = GRANT_IDLE;
    if (if_take) begin
      state_d = GRANT_IF;
    end else if (dm_take) begin
      state_d = GRANT_DM;
    end
  end

  // Route the single response slot to the requester that won last cycle.
  always_comb begin
    if_valid = 1'b0;
    dm_valid = 1'b0;
    case (state_q)
      GRANT_IF: if_valid = 1'b1;
      GRANT_DM: dm_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the ROM word into the winner's register; the loser holds.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      if_inst_q <= '0;
      dm_data_q <= '0;
      if_err_q  <= 1'b0;
      dm_err_q  <= 1'b0;
    end else begin
      if_err_q <= if_take & ~rom_aligned;
      dm_err_q <= dm_take & ~rom_aligned;
      if (if_take) begin
        if_inst_q <= rom_word;
      end
      if (dm_take) begin
        dm_data_q <= rom_word;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_valid  = if_valid;
  assign bus.dm_valid  = dm_valid;
  assign bus.if_inst   = if_inst_q;
  assign bus.dm_data   = dm_data_q;
  assign bus.if_err    = if_err_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.stall_req = bus.if_req & ~if_gnt;
  assign bus.rom_addr  = rom_addr;
  assign bus.rom_en    = (any_gnt && rom_aligned) ? CHIP_ENABLE : CHIP_DISABLE;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_inst_rom_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   check_cnt = 0;

  logic [31:0] rom_mem [0:255];

  always #5 clk = ~clk;

  inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  // Behavioural ROM: combinational word lookup on the ROM byte address.
  assign bus_a.rom_inst = rom_mem[bus_a.rom_addr[9:2]];
  assign bus_b.rom_inst = rom_mem[bus_b.rom_addr[9:2]];

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .CNT_W(3)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0), .CNT_W(3)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic drive_a(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic [31:0] da);
    bus_a.if_req   = ir;
    bus_a.if_addr  = ia;
    bus_a.if_flush = fl;
    bus_a.dm_req   = dr;
    bus_a.dm_addr  = da;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_a(1'b1, 32'h0, 1'b0, 1'b1, 32'h4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_cnt++;
      if (bus_a.if_gnt !== 1'b0 || bus_a.dm_gnt !== 1'b0 || bus_a.rom_en !== 1'b0)
        $display("FAIL reset_gnt c%0d got if_gnt=%b dm_gnt=%b rom_en=%b exp 0/0/0", c, bus_a.if_gnt, bus_a.dm_gnt, bus_a.rom_en);
      else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++;
      if (bus_a.if_valid !== 1'b0 || bus_a.dm_valid !== 1'b0 || bus_a.if_inst !== 32'h0 || bus_a.dm_data !== 32'h0)
        $display("FAIL reset_resp c%0d got ifv=%b dmv=%b if_inst=%h dm_data=%h exp 0", c, bus_a.if_valid, bus_a.dm_valid, bus_a.if_inst, bus_a.dm_data);
      else pass_cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (bus_a.dm_gnt !== 1'b1 || bus_a.if_gnt !== 1'b0)
      $display("FAIL reset_release_gnt got dm_gnt=%b if_gnt=%b exp 1/0", bus_a.dm_gnt, bus_a.if_gnt);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.dm_valid !== 1'b1 || bus_a.dm_data !== rom_mem[1])
      $display("FAIL reset_release_resp got dmv=%b data=%h exp 1/%h", bus_a.dm_valid, bus_a.dm_data, rom_mem[1]);
    else pass_cnt++;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 32'(4 * i), 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_cnt++;
      if (bus_a.if_gnt !== 1'b1 || bus_a.stall_req !== 1'b0 || bus_a.rom_en !== 1'b1 || bus_a.rom_addr !== 32'(4 * i))
        $display("FAIL fetch_gnt i%0d got gnt=%b stall=%b en=%b addr=%h exp 1/0/1/%h", i, bus_a.if_gnt, bus_a.stall_req, bus_a.rom_en, bus_a.rom_addr, 4 * i);
      else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++;
      if (bus_a.if_valid !== 1'b1 || bus_a.if_inst !== 32'hA0 + 32'(i) || bus_a.if_err !== 1'b0 || bus_a.dm_valid !== 1'b0)
        $display("FAIL fetch_resp i%0d got v=%b inst=%h err=%b dmv=%b exp 1/%h/0/0", i, bus_a.if_valid, bus_a.if_inst, bus_a.if_err, bus_a.dm_valid, 32'hA0 + 32'(i));
      else pass_cnt++;
    end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.if_valid !== 1'b0)
      $display("FAIL fetch_idle got if_valid=%b exp 0", bus_a.if_valid);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    drive_a(1'b1, 32'h20, 1'b0, 1'b1, 32'h40);
    for (int c = 0; c < 6; c++) begin
      logic exp_if;
      exp_if = (c == 4);
      @(negedge clk);
      check_cnt++;
      if (bus_a.if_gnt !== exp_if || bus_a.dm_gnt !== !exp_if || bus_a.stall_req !== !exp_if)
        $display("FAIL contention_gnt c%0d got if=%b dm=%b stall=%b exp %b/%b/%b", c, bus_a.if_gnt, bus_a.dm_gnt, bus_a.stall_req, exp_if, !exp_if, !exp_if);
      else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++;
      if (exp_if ? (bus_a.if_valid !== 1'b1 || bus_a.dm_valid !== 1'b0 || bus_a.if_inst !== rom_mem[8])
                 : (bus_a.dm_valid !== 1'b1 || bus_a.if_valid !== 1'b0 || bus_a.dm_data !== rom_mem[16]))
        $display("FAIL contention_resp c%0d got ifv=%b dmv=%b inst=%h data=%h", c, bus_a.if_valid, bus_a.dm_valid, bus_a.if_inst, bus_a.dm_data);
      else pass_cnt++;
    end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    drive_a(1'b0, 32'h0, 1'b0, 1'b1, 32'h6);
    @(negedge clk);
    check_cnt++;
    if (bus_a.dm_gnt !== 1'b1 || bus_a.rom_en !== 1'b0 || bus_a.rom_addr !== 32'h6)
      $display("FAIL misaligned_dm_gnt got gnt=%b en=%b addr=%h exp 1/0/6", bus_a.dm_gnt, bus_a.rom_en, bus_a.rom_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.dm_valid !== 1'b1 || bus_a.dm_err !== 1'b1 || bus_a.dm_data !== 32'h0)
      $display("FAIL misaligned_dm_resp got v=%b err=%b data=%h exp 1/1/0", bus_a.dm_valid, bus_a.dm_err, bus_a.dm_data);
    else pass_cnt++;
    drive_a(1'b1, 32'h2, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_cnt++;
    if (bus_a.if_gnt !== 1'b1 || bus_a.rom_en !== 1'b0)
      $display("FAIL misaligned_if_gnt got gnt=%b en=%b exp 1/0", bus_a.if_gnt, bus_a.rom_en);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.if_valid !== 1'b1 || bus_a.if_err !== 1'b1 || bus_a.if_inst !== 32'h0 || bus_a.dm_err !== 1'b0)
      $display("FAIL misaligned_if_resp got v=%b err=%b inst=%h dm_err=%b exp 1/1/0/0", bus_a.if_valid, bus_a.if_err, bus_a.if_inst, bus_a.dm_err);
    else pass_cnt++;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    drive_a(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive_a(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_cnt++;
    if (bus_a.if_gnt !== 1'b1)
      $display("FAIL flush_gnt got if_gnt=%b exp 1", bus_a.if_gnt);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.if_valid !== 1'b0 || bus_a.if_inst !== 32'hA2)
      $display("FAIL flush_resp got v=%b inst=%h exp 0/000000a2", bus_a.if_valid, bus_a.if_inst);
    else pass_cnt++;
    drive_a(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.if_valid !== 1'b1 || bus_a.if_inst !== rom_mem[5])
      $display("FAIL flush_next_resp got v=%b inst=%h exp 1/%h", bus_a.if_valid, bus_a.if_inst, rom_mem[5]);
    else pass_cnt++;
    drive_a(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.dm_valid !== 1'b1 || bus_a.dm_data !== 32'hA0 || bus_a.if_valid !== 1'b0)
      $display("FAIL flush_nogrant got dmv=%b data=%h ifv=%b exp 1/000000a0/0", bus_a.dm_valid, bus_a.dm_data, bus_a.if_valid);
    else pass_cnt++;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_no_fairness();
    bus_b.if_req  = 1'b1;
    bus_b.if_addr = 32'h0;
    bus_b.dm_req  = 1'b1;
    bus_b.dm_addr = 32'h4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_cnt++;
      if (bus_b.dm_gnt !== 1'b1 || bus_b.if_gnt !== 1'b0 || bus_b.stall_req !== 1'b1)
        $display("FAIL nofair_gnt c%0d got dm=%b if=%b stall=%b exp 1/0/1", c, bus_b.dm_gnt, bus_b.if_gnt, bus_b.stall_req);
      else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++;
      if (bus_b.dm_valid !== 1'b1 || bus_b.if_valid !== 1'b0 || bus_b.dm_data !== rom_mem[1])
        $display("FAIL nofair_resp c%0d got dmv=%b ifv=%b data=%h", c, bus_b.dm_valid, bus_b.if_valid, bus_b.dm_data);
      else pass_cnt++;
    end
    bus_b.if_req = 1'b0;
    bus_b.dm_req = 1'b0;
  endtask

  // Reference model: a fetch starvation tally; fetch wins contention once it
  // has been refused four times in a row.
  task automatic test_random();
    int          starve;
    logic [31:0] e_if_inst;
    logic [31:0] e_dm_data;
    starve    = 0;
    e_if_inst = rom_mem[5];
    e_dm_data = 32'hA0;
    for (int n = 0; n < 300; n++) begin
      logic        ir, dr, fl, e_en, e_if_v, e_dm_v, e_if_err, e_dm_err;
      logic [31:0] ia, da, e_addr;
      int          win;
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 5) == 0);
      ia = $urandom;
      da = $urandom;
      if ($urandom_range(0, 4) != 0) ia[1:0] = 2'b00;
      if ($urandom_range(0, 4) != 0) da[1:0] = 2'b00;
      drive_a(ir, ia, fl, dr, da);
      if (ir && (!dr || starve == 4)) win = 1;
      else if (dr) win = 2;
      else win = 0;
      e_addr = (win == 1) ? ia : (win == 2) ? da : 32'h0;
      e_en   = (win != 0) && (e_addr % 4 == 0);
      @(negedge clk);
      check_cnt++;
      if (bus_a.if_gnt !== (win == 1) || bus_a.dm_gnt !== (win == 2) || bus_a.stall_req !== (ir && win != 1)
          || bus_a.rom_en !== e_en || bus_a.rom_addr !== e_addr)
        $display("FAIL rand_gnt n%0d got if=%b dm=%b stall=%b en=%b addr=%h exp win=%0d en=%b addr=%h",
                 n, bus_a.if_gnt, bus_a.dm_gnt, bus_a.stall_req, bus_a.rom_en, bus_a.rom_addr, win, e_en, e_addr);
      else pass_cnt++;
      @(posedge clk); #1;
      if (win == 1) starve = 0;
      else if (ir && starve < 4) starve++;
      e_if_v   = (win == 1) && !fl;
      e_dm_v   = (win == 2);
      e_if_err = e_if_v && (ia % 4 != 0);
      e_dm_err = e_dm_v && (da % 4 != 0);
      if (e_if_v) e_if_inst = (ia % 4 == 0) ? rom_mem[ia[9:2]] : 32'h0;
      if (e_dm_v) e_dm_data = (da % 4 == 0) ? rom_mem[da[9:2]] : 32'h0;
      check_cnt++;
      if (bus_a.if_valid !== e_if_v || bus_a.if_err !== e_if_err || bus_a.if_inst !== e_if_inst)
        $display("FAIL rand_if_resp n%0d got v=%b err=%b inst=%h exp %b/%b/%h", n, bus_a.if_valid, bus_a.if_err, bus_a.if_inst, e_if_v, e_if_err, e_if_inst);
      else pass_cnt++;
      check_cnt++;
      if (bus_a.dm_valid !== e_dm_v || bus_a.dm_err !== e_dm_err || bus_a.dm_data !== e_dm_data)
        $display("FAIL rand_dm_resp n%0d got v=%b err=%b data=%h exp %b/%b/%h", n, bus_a.dm_valid, bus_a.dm_err, bus_a.dm_data, e_dm_v, e_dm_err, e_dm_data);
      else pass_cnt++;
    end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    drive_a(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_cnt++;
    if (bus_a.if_gnt !== 1'b1)
      $display("FAIL midrst_pre_gnt got if_gnt=%b exp 1", bus_a.if_gnt);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if (bus_a.if_gnt !== 1'b0 || bus_a.rom_en !== 1'b0)
      $display("FAIL midrst_gnt got if_gnt=%b rom_en=%b exp 0/0", bus_a.if_gnt, bus_a.rom_en);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (bus_a.if_valid !== 1'b0 || bus_a.if_inst !== 32'h0)
      $display("FAIL midrst_resp got v=%b inst=%h exp 0/0", bus_a.if_valid, bus_a.if_inst);
    else pass_cnt++;
    rst = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'hA0;
    rom_mem[1] = 32'hA1;
    rom_mem[2] = 32'hA2;
    bus_b.if_req   = 1'b0;
    bus_b.if_addr  = 32'h0;
    bus_b.if_flush = 1'b0;
    bus_b.dm_req   = 1'b0;
    bus_b.dm_addr  = 32'h0;
    test_reset();
    test_fetch_only();
    test_contention();
    test_misaligned();
    test_flush();
    test_no_fairness();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d of %0d checks", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

endmodule
